// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared decode constants, field layout and decoded-op type
package cpu_pkg;

    // Instruction classes, taken from opcode[7:4]
    localparam logic [3:0] CLS_NOP = 4'h0;
    localparam logic [3:0] CLS_IMM = 4'h1;
    localparam logic [3:0] CLS_RR  = 4'h2;

    // Field bit positions within the 32-bit instruction word
    localparam int OPC_LSB   = 24;
    localparam int FLD_D_LSB = 16;
    localparam int FLD_A_LSB = 8;
    localparam int FLD_B_LSB = 0;
    localparam int FLD_W     = 8;
    localparam int IMM_W     = 16;

    // Decoded op. Selects are carried at full field width; the pipe
    // truncates them to its configured select width.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  sel_d;
        logic [7:0]  sel_a;
        logic [7:0]  sel_b;
        logic [31:0] imm;
        logic        use_imm;
        logic        writes;
        logic        illegal;
        logic        use_a;
        logic        use_b;
    } dec_op_t;

    // True when a register field names a register beyond the file size
    function automatic logic fld_out_of_range(input logic [FLD_W-1:0] fld, input int sel_w);
        return (fld >> sel_w) != '0;
    endfunction

endpackage

// File: rtl/cpu_scoreboard.sv
// rtl/cpu_scoreboard.sv - pending-write bitmap with writeback bypass on lookups
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   set_en, set_sel     mark a register as having a write in flight
//   clr_en, clr_sel     writeback retiring a register
//   rd_a_sel, rd_b_sel  source registers being looked up
//   pend_a, pend_b      source still pending after this cycle's writeback
//   busy                any register pending
module cpu_scoreboard #(
    parameter int SEL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [SEL_W-1:0] set_sel,
    input  logic             clr_en,
    input  logic [SEL_W-1:0] clr_sel,
    input  logic [SEL_W-1:0] rd_a_sel,
    input  logic [SEL_W-1:0] rd_b_sel,
    output logic             pend_a,
    output logic             pend_b,
    output logic             busy
);

    localparam int NUM_REGS = 2 ** SEL_W;

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] live;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_sel] = 1'b1;
        if (clr_en) clr_mask[clr_sel] = 1'b1;
    end

    // A writeback landing this cycle already resolves the dependency
    assign live   = pending & ~clr_mask;
    assign pend_a = live[rd_a_sel];
    assign pend_b = live[rd_b_sel];
    assign busy   = |pending;

    // Clear first, then set, so a same-cycle set of the same register wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= live | set_mask;
    end

endmodule

// File: rtl/cpu_decode_pipe.sv
// rtl/cpu_decode_pipe.sv - pipelined instruction decode with RAW hazard stall
//
// Ports:
//   CLK, RST                clock, asynchronous active-high reset
//   flush                   drop the output stage contents
//   in_valid/in_ready       instruction handshake from fetch
//   instruction             raw 32-bit instruction
//   out_valid/out_ready     decoded-op handshake to execute
//   out_opcode, regD/A/B_sel, out_imm, out_use_imm, out_writes, out_illegal
//                           registered decoded op
//   wb_valid, wb_sel        writeback retiring a register
//   busy                    any pending write outstanding
//   stall_count             saturating count of hazard-stall cycles
module cpu_decode_pipe
    import cpu_pkg::*;
#(
    parameter int REG_SEL_W   = 8,
    parameter int STALL_CNT_W = 16,
    parameter int ZERO_REG    = 1
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instruction,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_opcode,
    output logic [REG_SEL_W-1:0]   regD_sel,
    output logic [REG_SEL_W-1:0]   regA_sel,
    output logic [REG_SEL_W-1:0]   regB_sel,
    output logic [31:0]            out_imm,
    output logic                   out_use_imm,
    output logic                   out_writes,
    output logic                   out_illegal,
    input  logic                   wb_valid,
    input  logic [REG_SEL_W-1:0]   wb_sel,
    output logic                   busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [FLD_W-1:0] fld_d;
    logic [FLD_W-1:0] fld_a;
    logic [FLD_W-1:0] fld_b;
    dec_op_t          dec;

    assign fld_d = instruction[FLD_D_LSB +: FLD_W];
    assign fld_a = instruction[FLD_A_LSB +: FLD_W];
    assign fld_b = instruction[FLD_B_LSB +: FLD_W];

    always_comb begin
        dec        = '0;
        dec.opcode = instruction[OPC_LSB +: 8];
        case (dec.opcode[7:4])
            CLS_NOP: begin
                dec.writes = 1'b0;
            end
            CLS_IMM: begin
                dec.sel_d   = fld_d;
                dec.sel_a   = fld_d;
                dec.use_a   = 1'b1;
                dec.use_imm = 1'b1;
                dec.writes  = 1'b1;
                dec.imm     = dec.opcode[0]
                            ? {{(32-IMM_W){instruction[IMM_W-1]}}, instruction[IMM_W-1:0]}
                            : {{(32-IMM_W){1'b0}}, instruction[IMM_W-1:0]};
                dec.illegal = fld_out_of_range(fld_d, REG_SEL_W);
            end
            CLS_RR: begin
                dec.sel_d   = fld_d;
                dec.sel_a   = fld_a;
                dec.sel_b   = fld_b;
                dec.use_a   = 1'b1;
                dec.use_b   = 1'b1;
                dec.writes  = 1'b1;
                dec.illegal = fld_out_of_range(fld_d, REG_SEL_W)
                            | fld_out_of_range(fld_a, REG_SEL_W)
                            | fld_out_of_range(fld_b, REG_SEL_W);
            end
            default: begin
                // Undefined class: fields pass through so execute can trap on them
                dec.sel_d   = fld_d;
                dec.sel_a   = fld_a;
                dec.sel_b   = fld_b;
                dec.illegal = 1'b1;
            end
        endcase
    end

    logic [REG_SEL_W-1:0] dec_d;
    logic [REG_SEL_W-1:0] dec_a;
    logic [REG_SEL_W-1:0] dec_b;

    assign dec_d = dec.sel_d[REG_SEL_W-1:0];
    assign dec_a = dec.sel_a[REG_SEL_W-1:0];
    assign dec_b = dec.sel_b[REG_SEL_W-1:0];

    logic pend_a;
    logic pend_b;
    logic sb_set;
    logic out_fire;
    logic in_fire;
    logic stage_free;
    logic haz_a;
    logic haz_b;
    logic hazard;

    assign out_fire   = out_valid && out_ready;
    assign stage_free = !out_valid || out_ready;

    // The op leaving the output stage becomes pending next cycle; a flushed
    // op never reaches execute, and r0 never holds a write when hardwired.
    assign sb_set = out_fire && !flush && out_writes && !out_illegal
                 && !(ZERO_EN && regD_sel == '0);

    cpu_scoreboard #(
        .SEL_W (REG_SEL_W)
    ) u_scoreboard (
        .clk      (CLK),
        .rst      (RST),
        .set_en   (sb_set),
        .set_sel  (regD_sel),
        .clr_en   (wb_valid),
        .clr_sel  (wb_sel),
        .rd_a_sel (dec_a),
        .rd_b_sel (dec_b),
        .pend_a   (pend_a),
        .pend_b   (pend_b),
        .busy     (busy)
    );

    // A source also conflicts with the op still sitting in the output stage,
    // because its scoreboard bit is only set once it hands off to execute.
    assign haz_a = dec.use_a && !(ZERO_EN && dec_a == '0)
                && (pend_a || (out_valid && out_writes && regD_sel == dec_a));
    assign haz_b = dec.use_b && !(ZERO_EN && dec_b == '0)
                && (pend_b || (out_valid && out_writes && regD_sel == dec_b));
    assign hazard = haz_a || haz_b;

    assign in_ready = !RST && !flush && stage_free && !(in_valid && hazard);
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            regD_sel    <= '0;
            regA_sel    <= '0;
            regB_sel    <= '0;
            out_imm     <= '0;
            out_use_imm <= 1'b0;
            out_writes  <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            regD_sel    <= '0;
            regA_sel    <= '0;
            regB_sel    <= '0;
            out_imm     <= '0;
            out_use_imm <= 1'b0;
            out_writes  <= 1'b0;
            out_illegal <= 1'b0;
        end else if (in_fire) begin
            out_valid   <= 1'b1;
            out_opcode  <= dec.opcode;
            regD_sel    <= dec_d;
            regA_sel    <= dec_a;
            regB_sel    <= dec_b;
            out_imm     <= dec.imm;
            out_use_imm <= dec.use_imm;
            out_writes  <= dec.writes;
            out_illegal <= dec.illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Only hazard stalls are counted; back-pressure from execute is not
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_count <= '0;
        end else if (in_valid && hazard && stage_free && stall_count != {STALL_CNT_W{1'b1}}) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_decode_pipe.sv
// tb/tb_cpu_decode_pipe.sv - self-checking bench for cpu_decode_pipe
module tb_cpu_decode_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        flush, in_valid, out_ready, wb_valid;
    logic [31:0] instruction;
    logic [7:0]  wb_sel;
    logic        in_ready, out_valid, out_use_imm, out_writes, out_illegal, busy;
    logic [7:0]  out_opcode, regD_sel, regA_sel, regB_sel;
    logic [31:0] out_imm;
    logic [15:0] stall_count;

    cpu_decode_pipe u_dut (
        .CLK(clk), .RST(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .regD_sel(regD_sel), .regA_sel(regA_sel), .regB_sel(regB_sel),
        .out_imm(out_imm), .out_use_imm(out_use_imm), .out_writes(out_writes),
        .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_sel(wb_sel), .busy(busy),
        .stall_count(stall_count)
    );

    logic        i4_valid, o4_ready, wb4_valid;
    logic [31:0] instr4;
    logic [3:0]  wb4_sel;
    logic        i4_ready, o4_valid, o4_use_imm, o4_writes, o4_illegal, busy4;
    logic [7:0]  o4_opcode;
    logic [3:0]  o4_d, o4_a, o4_b;
    logic [31:0] o4_imm;
    logic [15:0] stall4;

    cpu_decode_pipe #(.REG_SEL_W(4)) u_dut4 (
        .CLK(clk), .RST(rst), .flush(1'b0), .in_valid(i4_valid), .in_ready(i4_ready),
        .instruction(instr4), .out_valid(o4_valid), .out_ready(o4_ready),
        .out_opcode(o4_opcode), .regD_sel(o4_d), .regA_sel(o4_a), .regB_sel(o4_b),
        .out_imm(o4_imm), .out_use_imm(o4_use_imm), .out_writes(o4_writes),
        .out_illegal(o4_illegal), .wb_valid(wb4_valid), .wb_sel(wb4_sel), .busy(busy4),
        .stall_count(stall4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        bit [7:0]  opcode;
        bit [7:0]  d;
        bit [7:0]  a;
        bit [7:0]  b;
        bit [31:0] imm;
        bit        ui;
        bit        wr;
        bit        il;
        bit        ua;
        bit        ub;
    } exp_t;

    typedef struct {
        bit [31:0] instr;
        exp_t      e;
    } vec_t;

    // Reference decode straight from the field rules, using integer arithmetic
    function automatic exp_t ref_decode(input bit [31:0] w, input int sw);
        exp_t e;
        int cls, d, a, b, lim, v;
        cls = int'(w >> 28);
        d   = int'((w >> 16) & 32'hFF);
        a   = int'((w >> 8) & 32'hFF);
        b   = int'(w & 32'hFF);
        lim = 1 << sw;
        e = '0;
        e.opcode = w[31:24];
        if (cls == 1) begin
            e.d = 8'(d % lim); e.a = e.d; e.ua = 1; e.ui = 1; e.wr = 1;
            v = int'(w & 32'hFFFF);
            if (w[24] && v >= 32768) v = v - 65536;
            e.imm = 32'(v);
            e.il = (d >= lim);
        end else if (cls == 2) begin
            e.d = 8'(d % lim); e.a = 8'(a % lim); e.b = 8'(b % lim);
            e.ua = 1; e.ub = 1; e.wr = 1;
            e.il = (d >= lim) || (a >= lim) || (b >= lim);
        end else if (cls != 0) begin
            e.d = 8'(d % lim); e.a = 8'(a % lim); e.b = 8'(b % lim);
            e.il = 1;
        end
        return e;
    endfunction

    task automatic cmp_out(input string tag, input exp_t e, input bit v);
        chk({tag, "_valid"},   {31'd0, out_valid},   {31'd0, v});
        chk({tag, "_opcode"},  {24'd0, out_opcode},  {24'd0, e.opcode});
        chk({tag, "_regD"},    {24'd0, regD_sel},    {24'd0, e.d});
        chk({tag, "_regA"},    {24'd0, regA_sel},    {24'd0, e.a});
        chk({tag, "_regB"},    {24'd0, regB_sel},    {24'd0, e.b});
        chk({tag, "_imm"},     out_imm,              e.imm);
        chk({tag, "_use_imm"}, {31'd0, out_use_imm}, {31'd0, e.ui});
        chk({tag, "_writes"},  {31'd0, out_writes},  {31'd0, e.wr});
        chk({tag, "_illegal"}, {31'd0, out_illegal}, {31'd0, e.il});
    endtask

    // Behavioural model state for the randomized phase
    bit   m_valid;
    exp_t m_op;
    bit   m_pend [256];
    int   m_stall;

    function automatic bit src_hz(input int r, input bit wbv, input int wbs);
        if (r == 0) return 1'b0;
        if (m_pend[r] && !(wbv && wbs == r)) return 1'b1;
        if (m_valid && m_op.wr && int'(m_op.d) == r) return 1'b1;
        return 1'b0;
    endfunction

    vec_t vecs [8];

    initial begin
        exp_t e;
        flush = 0; in_valid = 0; out_ready = 0; wb_valid = 0; instruction = 0; wb_sel = 0;
        i4_valid = 0; o4_ready = 1; wb4_valid = 0; instr4 = 0; wb4_sel = 0;

        vecs[0] = '{32'h21020304, '{8'h21, 8'h02, 8'h03, 8'h04, 32'h0, 0, 1, 0, 0, 0}};
        vecs[1] = '{32'h10123456, '{8'h10, 8'h12, 8'h12, 8'h00, 32'h00003456, 1, 1, 0, 0, 0}};
        vecs[2] = '{32'h11128000, '{8'h11, 8'h12, 8'h12, 8'h00, 32'hFFFF8000, 1, 1, 0, 0, 0}};
        vecs[3] = '{32'h00ABCDEF, '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0, 0, 0, 0, 0, 0}};
        vecs[4] = '{32'h55010203, '{8'h55, 8'h01, 8'h02, 8'h03, 32'h0, 0, 0, 1, 0, 0}};
        vecs[5] = '{32'h2FFF0102, '{8'h2F, 8'hFF, 8'h01, 8'h02, 32'h0, 0, 1, 0, 0, 0}};
        vecs[6] = '{32'h11FF7FFF, '{8'h11, 8'hFF, 8'hFF, 8'h00, 32'h00007FFF, 1, 1, 0, 0, 0}};
        vecs[7] = '{32'h1000FFFF, '{8'h10, 8'h00, 8'h00, 8'h00, 32'h0000FFFF, 1, 1, 0, 0, 0}};

        // Reset state
        @(negedge clk);
        cmp_out("reset", '0, 1'b0);
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_stall", {16'd0, stall_count}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk); rst = 0; #1;
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Narrow-select build: out-of-range fields and undefined class
        @(negedge clk); i4_valid = 1; instr4 = 32'h21120304;
        @(negedge clk); i4_valid = 0;
        chk("w4_illegal_rng", {31'd0, o4_illegal}, 32'd1);
        chk("w4_valid",       {31'd0, o4_valid},   32'd1);
        @(negedge clk);
        chk("w4_no_sb_set", {31'd0, busy4}, 32'd0);
        i4_valid = 1; instr4 = 32'h55000000;
        @(negedge clk); i4_valid = 0;
        chk("w4_illegal_cls", {31'd0, o4_illegal}, 32'd1);
        chk("w4_cls_writes",  {31'd0, o4_writes},  32'd0);
        @(negedge clk); i4_valid = 1; instr4 = 32'h21020304;
        @(negedge clk); i4_valid = 0;
        chk("w4_legal", {31'd0, o4_illegal}, 32'd0);
        chk("w4_regD",  {28'd0, o4_d}, 32'd2);
        @(negedge clk);
        chk("w4_sb_set", {31'd0, busy4}, 32'd1);
        wb4_valid = 1; wb4_sel = 4'd2;
        @(negedge clk); wb4_valid = 0;

        // Table of decode vectors, each drained and retired before the next
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); in_valid = 1; instruction = vecs[i].instr; #1;
            chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            @(negedge clk); in_valid = 0;
            cmp_out($sformatf("vec%0d", i), vecs[i].e, 1'b1);
            e = ref_decode(vecs[i].instr, 8);
            chk($sformatf("vec%0d_refmodel", i), {e.d, e.a, e.b, 5'd0, e.ui, e.wr, e.il},
                {vecs[i].e.d, vecs[i].e.a, vecs[i].e.b, 5'd0, vecs[i].e.ui, vecs[i].e.wr, vecs[i].e.il});
            @(negedge clk);
            chk($sformatf("vec%0d_busy", i), {31'd0, busy},
                {31'd0, vecs[i].e.wr && !vecs[i].e.il && vecs[i].e.d != 0});
            wb_valid = 1; wb_sel = vecs[i].e.d;
            @(negedge clk); wb_valid = 0;
            chk($sformatf("vec%0d_busy_clr", i), {31'd0, busy}, 32'd0);
        end

        // RAW stall released by a same-cycle writeback
        @(negedge clk); in_valid = 1; instruction = 32'h21020304;
        @(negedge clk); instruction = 32'h21050203; #1;
        chk("raw_ready_outstage", {31'd0, in_ready}, 32'd0);
        @(negedge clk); #1;
        chk("raw_stall1", {16'd0, stall_count}, 32'd1);
        chk("raw_ready_sb", {31'd0, in_ready}, 32'd0);
        chk("raw_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("raw_stall2", {16'd0, stall_count}, 32'd2);
        wb_valid = 1; wb_sel = 8'd2; #1;
        chk("raw_wb_bypass_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); wb_valid = 0; in_valid = 0;
        e = ref_decode(32'h21050203, 8);
        cmp_out("raw_second", e, 1'b1);
        chk("raw_stall_hold", {16'd0, stall_count}, 32'd2);
        @(negedge clk); wb_valid = 1; wb_sel = 8'd5;
        @(negedge clk); wb_valid = 0;
        chk("raw_busy_clr", {31'd0, busy}, 32'd0);

        // Back-pressure with a hazarding input held: not counted as a stall
        @(negedge clk); in_valid = 1; instruction = 32'h21060708; #1;
        chk("bp_ready0", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); out_ready = 0; instruction = 32'h21090A06; #1;
            chk($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp%0d_regD", k), {24'd0, regD_sel}, 32'd6);
            chk($sformatf("bp%0d_regB", k), {24'd0, regB_sel}, 32'd8);
            chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
            chk($sformatf("bp%0d_stall", k), {16'd0, stall_count}, 32'd2);
        end
        @(negedge clk); in_valid = 0; out_ready = 1;
        chk("bp_stall_end", {16'd0, stall_count}, 32'd2);

        // Flush drops the output op and never marks it pending
        @(negedge clk); in_valid = 1; instruction = 32'h21070000; #1;
        chk("fl_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); in_valid = 0; flush = 1; #1;
        chk("fl_valid_before", {31'd0, out_valid}, 32'd1);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk); flush = 0;
        chk("fl_valid_after", {31'd0, out_valid}, 32'd0);
        chk("fl_busy_kept", {31'd0, busy}, 32'd1);
        wb_valid = 1; wb_sel = 8'd6;
        @(negedge clk); wb_valid = 0;
        chk("fl_no_sb_set", {31'd0, busy}, 32'd0);

        // Reset asserted in the middle of a stall
        @(negedge clk); in_valid = 1; instruction = 32'h21020304;
        @(negedge clk); instruction = 32'h21050203; #1;
        chk("rs_ready_stall", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("rs_stall3", {16'd0, stall_count}, 32'd3);
        chk("rs_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1; #1;
        cmp_out("rs_async", '0, 1'b0);
        chk("rs_busy0",  {31'd0, busy}, 32'd0);
        chk("rs_stall0", {16'd0, stall_count}, 32'd0);
        chk("rs_in_ready_held", {31'd0, in_ready}, 32'd0);
        @(negedge clk); rst = 0; #1;
        chk("rs_in_ready_release", {31'd0, in_ready}, 32'd1);
        @(negedge clk); in_valid = 0;

        // Randomized phase against the behavioural model
        @(negedge clk); rst = 1; in_valid = 0; wb_valid = 0; flush = 0;
        @(negedge clk); rst = 0;
        m_valid = 0; m_op = '0; m_stall = 0;
        for (int r = 0; r < 256; r++) m_pend[r] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit   iv, ordy, wbv, fl, hz, free, exp_ready, any;
            int   wbs, k, cls;
            bit [7:0] d, a, b;
            exp_t dd;
            @(negedge clk);
            cmp_out("rnd", m_op, m_valid);
            any = 0;
            for (int r = 0; r < 256; r++) any |= m_pend[r];
            chk("rnd_busy",  {31'd0, busy}, {31'd0, any});
            chk("rnd_stall", {16'd0, stall_count}, 32'(m_stall));

            k = int'($urandom_range(0, 9));
            cls = (k == 0) ? 0 : (k <= 3) ? 1 : (k <= 8) ? 2 : int'($urandom_range(3, 15));
            d = ($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            a = (cls == 1) ? 8'($urandom) : 8'($urandom_range(0, 7));
            b = (cls == 1) ? 8'($urandom) : 8'($urandom_range(0, 7));
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            wbv  = ($urandom_range(0, 9) < 3);
            fl   = ($urandom_range(0, 29) == 0);
            wbs  = int'($urandom_range(0, 7));
            in_valid = iv; out_ready = ordy; wb_valid = wbv; wb_sel = 8'(wbs); flush = fl;
            instruction = {4'(cls), 4'($urandom), d, a, b};
            #1;
            dd = ref_decode(instruction, 8);
            hz = (dd.ua && src_hz(int'(dd.a), wbv, wbs)) || (dd.ub && src_hz(int'(dd.b), wbv, wbs));
            free = !m_valid || ordy;
            exp_ready = !fl && free && !(iv && hz);
            chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, exp_ready});

            if (wbv) m_pend[wbs] = 0;
            if (m_valid && ordy && !fl && m_op.wr && !m_op.il && m_op.d != 0) m_pend[m_op.d] = 1;
            if (iv && hz && free && m_stall < 65535) m_stall++;
            if (fl) begin
                m_valid = 0; m_op = '0;
            end else if (iv && exp_ready) begin
                m_valid = 1; m_op = dd; m_op.ua = 0; m_op.ub = 0;
            end else if (ordy) begin
                m_valid = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_decode_pipe.md
Name: cpu_decode_pipe

Overview:
- Parametrised, pipelined successor to the CPU decode stage: decodes one 32-bit instruction per cycle into register selects, destination, immediate and control flags.
- valid/ready handshakes on both sides, so it sits between fetch and execute.
- Pending-write scoreboard stalls on RAW hazards; execute writeback clears entries.
- Supports flush and a saturating stall counter for perf monitoring.

Parameters:
- REG_SEL_W, 8, register select width (4..8); NUM_REGS = 2**REG_SEL_W.
- STALL_CNT_W, 16, stall counter width.
- ZERO_REG, 1, if 1 then r0 is hardwired: never marked pending, never hazards.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous active-high reset.
- flush  in  1  drop the output stage contents.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage accepts instruction this cycle.
- instruction  in  32  raw instruction word.
- out_valid  out  1  decoded op valid.
- out_ready  in  1  execute accepts decoded op.
- out_opcode  out  8  instruction[31:24].
- regD_sel  out  REG_SEL_W  destination register.
- regA_sel  out  REG_SEL_W  source A.
- regB_sel  out  REG_SEL_W  source B.
- out_imm  out  32  extended immediate.
- out_use_imm  out  1  B operand is out_imm.
- out_writes  out  1  op writes regD.
- out_illegal  out  1  undefined class or out-of-range register field.
- wb_valid  in  1  writeback retiring.
- wb_sel  in  REG_SEL_W  register being written back.
- busy  out  1  any scoreboard bit set.
- stall_count  out  STALL_CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Field layout:
  - opcode = [31:24]; class = opcode[7:4].
  - D field = [23:16], A field = [15:8], B field = [7:0]. Each select is the low REG_SEL_W bits of its field.
  - Any register field with nonzero bits above REG_SEL_W sets illegal.
- Class 0x0 NOP: writes=0, no sources.
- Class 0x1 imm: D = [23:16], A = D, use_imm=1, writes=1. imm = [15:0], sign-extended if opcode[0]=1, else zero-extended. B is don't-care, 0.
- Class 0x2 reg-reg: D, A, B from fields; use_imm=0; writes=1; imm=0.
- Any other class: illegal=1, writes=0. The op still passes through so execute can trap.
- Output stage is a register; latency is 1 cycle from the input handshake to out_valid.
- Hazard occurs when a used source register (A, or B for class 0x2) is either:
  - set in (scoreboard & ~wb_mask), where wb_mask is the one-hot of wb_sel when wb_valid; or
  - equal to regD_sel while out_valid && out_writes.
- Any register with ZERO_REG && sel==0 never hazards.
- in_ready = (!out_valid || out_ready) && !(in_valid && hazard).
- Input handshake (in_valid && in_ready) loads the output stage and sets out_valid=1.
- Otherwise, out_valid clears on out_ready. out_valid may stay high across back-to-back accepts.
- Output fields stay stable while out_valid && !out_ready.
- Scoreboard:
  - Sets bit regD on the output handshake when out_writes and !illegal (skipped for r0 when ZERO_REG).
  - wb_valid clears bit wb_sel.
  - Set and clear of the same register in the same cycle: set wins.
- stall_count increments each cycle that in_valid && hazard && stage not blocked by out_ready; saturates at all-ones.
- flush (synchronous):
  - out_valid <= 0 and the output stage contents are dropped, with no scoreboard set.
  - in_ready is 0 during flush, so no input is accepted that cycle.
  - Scoreboard and wb handling continue unaffected.
- Reset (asynchronous, any time, including mid-stall):
  - out_valid=0 and all out_* fields = 0.
  - scoreboard=0, busy=0, stall_count=0.
  - in_ready rises the first cycle after RST deasserts.

Decomposition:
- Shared package cpu_pkg holds:
  - class constants CLS_NOP=4'h0, CLS_IMM=4'h1, CLS_RR=4'h2;
  - field bit positions;
  - the decoded-op struct typedef (opcode, sel D/A/B, imm, flags).
- One sub-module, cpu_scoreboard: holds the NUM_REGS pending bitmap; set/clear ports; combinational pending lookup for A/B with the wb bypass; busy output.
- The decode logic itself stays combinational inside cpu_decode_pipe.

Test Plan:
- Reset then 0x21020304 with out_ready=1 -> next cycle out_valid=1, regD=2, regA=3, regB=4, writes=1, use_imm=0; busy=1 the following cycle.
- 0x10123456 -> regD=0x12, regA=0x12, imm=0x00003456, use_imm=1. Then 0x11128000 -> imm=0xFFFF8000.
- 0x21020304 followed by 0x21050203 (reads r2) with no writeback -> in_ready=0 and stall_count increments each cycle. Pulse wb_valid with wb_sel=2 -> second instruction accepted that same cycle.
- out_ready=0 for 3 cycles with in_valid held -> outputs stable, in_ready=0, and stall_count unchanged (back-pressure is not a hazard).
- REG_SEL_W=4 build: 0x21120304 -> out_illegal=1, no scoreboard bit set. Opcode 0x55 -> out_illegal=1.
- Two more scenarios:
  - flush while out_valid=1 -> out_valid=0 next cycle, busy unchanged.
  - RST asserted mid-stall -> all outputs 0 immediately, in_ready=1 after release.
